axi_lite_req_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one AXI4_Lite_Master command port (AXI_Start/AXI_WriteEn/AXI_Addr/AXI_WData/AXI_RData/AXI_Done) between NUM_REQ requesters. It accepts one command at a time over per-requester valid/ready handshakes. It holds the command stable on the master port until AXI_Done, captures read data, and returns a one-cycle response to the granted requester. It sits between local bus clients (DMA, CSR engines, debug) and the AXI4-Lite master.

---
 rtl/axi_lite_arb_pkg.sv | 18 +
 rtl/axi_lite_req_arbiter_if.sv | 42 ++++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/axi_lite_req_arbiter.sv | 148 ++++++++++++++
 tb/tb_axi_lite_req_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_lite_arb_pkg.sv
// Shared definitions for the AXI4-Lite request arbiter.
// Holds the sequencer state encoding and the default widths used by the
// interface and the top level.
package axi_lite_arb_pkg;

    localparam int unsigned DefNumReq = 4;
    localparam int unsigned DefAddrW  = 32;
    localparam int unsigned DefDataW  = 32;

    // Command sequencer: grant in idle, pulse start, wait for done, respond.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StResp  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/axi_lite_req_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and the AXI4-Lite master.
// Signals:
//   req_valid/req_ready/req_write/req_addr/req_wdata - per-requester command
//   rsp_valid/rsp_rdata                               - completion back to requesters
//   m_start/m_write_en/m_addr/m_wdata/m_rdata/m_done  - shared master command port
// Modports:
//   slave  - the arbiter (accepts commands, drives the master port)
//   master - the environment (requesters plus the AXI4-Lite master)
interface axi_lite_req_arbiter_if
    import axi_lite_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DefNumReq,
    parameter int unsigned ADDR_W  = DefAddrW,
    parameter int unsigned DATA_W  = DefDataW
) ();

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;

    logic                      m_start;
    logic                      m_write_en;
    logic [ADDR_W-1:0]         m_addr;
    logic [DATA_W-1:0]         m_wdata;
    logic [DATA_W-1:0]         m_rdata;
    logic                      m_done;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, m_rdata, m_done,
        output req_ready, rsp_valid, rsp_rdata, m_start, m_write_en, m_addr, m_wdata
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, m_rdata, m_done,
        input  req_ready, rsp_valid, rsp_rdata, m_start, m_write_en, m_addr, m_wdata
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the first set bit of req_i searching upward from ptr_i+1, wrapping
// modulo N; ptr_i itself has lowest priority. Passing the last winner as
// ptr_i gives strict round-robin.
// Ports:
//   req_i     - request vector
//   ptr_i     - index of the previous winner
//   gnt_o     - one-hot grant (zero when no request)
//   gnt_idx_o - binary index of the grant (zero when no request)
//   any_o     - at least one request present
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] gnt_idx_o,
    output logic            any_o
);

    logic            found;
    logic [IdxW-1:0] cand;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        cand      = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IdxW'((32'(ptr_i) + k) % N);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                gnt_idx_o   = cand;
            end
        end
        any_o = |req_i;
    end

endmodule

// File: rtl/axi_lite_req_arbiter.sv
// Round-robin arbiter and sequencer sharing one AXI4-Lite master command
// port between NUM_REQ requesters. One command is in flight at a time; it is
// held on the master port from start until done, read data is captured on
// done and returned with a one-cycle pulse to the owning requester.
// Ports:
//   clk       - clock
//   rst       - asynchronous reset, active low
//   bus       - requester handshakes, responses and master command port
//   busy      - sequencer not idle
//   grant_idx - current or most recent owner
//   proto_err - sticky: master reported done outside the wait state
module axi_lite_req_arbiter
    import axi_lite_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DefNumReq,
    parameter int unsigned ADDR_W  = DefAddrW,
    parameter int unsigned DATA_W  = DefDataW,
    localparam int unsigned REQ_IDX_W = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    axi_lite_req_arbiter_if.slave bus,
    output logic                 busy,
    output logic [REQ_IDX_W-1:0] grant_idx,
    output logic                 proto_err
);

    arb_state_e           state_q, state_d;
    logic [REQ_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [REQ_IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic                 cmd_write_q, cmd_write_d;
    logic [ADDR_W-1:0]    cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0]    cmd_wdata_q, cmd_wdata_d;
    logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
    logic                 proto_err_q, proto_err_d;

    logic [NUM_REQ-1:0]   arb_gnt;
    logic [REQ_IDX_W-1:0] arb_gnt_idx;
    logic                 arb_any;

    logic                 sel_write;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .req_i     (bus.req_valid),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (arb_gnt),
        .gnt_idx_o (arb_gnt_idx),
        .any_o     (arb_any)
    );

    // One-hot grant steers the winner's payload into the command registers.
    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                sel_write = bus.req_write[i];
                sel_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_idx_d = grant_idx_q;
        cmd_write_d = cmd_write_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        rsp_data_d  = rsp_data_q;
        // A done outside WAIT does not belong to any command we issued.
        proto_err_d = proto_err_q | (bus.m_done && (state_q != StWait));

        unique case (state_q)
            StIdle: begin
                if (arb_any) begin
                    cmd_write_d = sel_write;
                    cmd_addr_d  = sel_addr;
                    cmd_wdata_d = sel_wdata;
                    grant_idx_d = arb_gnt_idx;
                    rr_ptr_d    = arb_gnt_idx;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                state_d = StWait;
            end
            StWait: begin
                // Master drives read data only in the done cycle; capture it now.
                if (bus.m_done) begin
                    rsp_data_d = bus.m_rdata;
                    state_d    = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            rr_ptr_q    <= REQ_IDX_W'(NUM_REQ - 1);
            grant_idx_q <= '0;
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            rsp_data_q  <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
            cmd_write_q <= cmd_write_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            rsp_data_q  <= rsp_data_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign grant_idx = grant_idx_q;
    assign proto_err = proto_err_q;

    // Ready is gated by reset so every output is zero while reset is held.
    assign bus.req_ready = (rst && (state_q == StIdle)) ? arb_gnt : '0;

    // Command stays on the master port from ISSUE through RESP.
    assign bus.m_start    = (state_q == StIssue);
    assign bus.m_write_en = busy & cmd_write_q;
    assign bus.m_addr     = busy ? cmd_addr_q : '0;
    assign bus.m_wdata    = busy ? cmd_wdata_q : '0;

    assign bus.rsp_valid = (state_q == StResp) ? (NUM_REQ'(1) << grant_idx_q) : '0;
    assign bus.rsp_rdata = (state_q == StResp) ? rsp_data_q : '0;

endmodule

// File: tb/tb_axi_lite_req_arbiter.sv
// Self-checking bench for axi_lite_req_arbiter: requesters raise commands
// and push the expected transaction order to a scoreboard; a monitor checks
// grants, the master port and responses against it; a small slave model
// answers m_start with m_done after a programmable latency.
module tb_axi_lite_req_arbiter;

    localparam int unsigned NumReq = 4;
    localparam int unsigned AddrW  = 32;
    localparam int unsigned DataW  = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       busy;
    logic [1:0] grant_idx;
    logic       proto_err;

    axi_lite_req_arbiter_if #(
        .NUM_REQ (NumReq),
        .ADDR_W  (AddrW),
        .DATA_W  (DataW)
    ) bus ();

    axi_lite_req_arbiter #(
        .NUM_REQ (NumReq),
        .ADDR_W  (AddrW),
        .DATA_W  (DataW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .grant_idx (grant_idx),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Main-owned controls.
    int req_cnt[NumReq] = '{default: 0};
    int spur_cnt   = 0;
    int slave_lat  = 1;
    bit slave_hang = 1'b0;

    // Driver-, slave- and monitor-owned state.
    int                srv_cnt[NumReq] = '{default: 0};
    int                spur_done = 0;
    int                slave_cnt = -1;
    bit                spur_flag = 1'b0;
    logic [NumReq-1:0] acc_seen  = '0;
    logic [NumReq-1:0] mon_acc;
    exp_t              mon_e;
    bit                start_due = 1'b0;
    bit                start_off_due = 1'b0;
    bit                rsp_due = 1'b0;
    bit                zero_due = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] slave_rdata(input logic [31:0] addr);
        if (addr == 32'h2000_0004) return 32'h1234_5678;
        return addr ^ 32'hA5A5_5A5A;
    endfunction

    function automatic logic [NumReq-1:0] onehot(input int i);
        logic [NumReq-1:0] one;
        one = 1;
        return one << i;
    endfunction

    // Requester i offers a command; the expected grant order is the push order.
    task automatic raise(input int i, input logic wr, input logic [31:0] a,
                         input logic [31:0] d);
        exp_t e;
        bus.req_write[i]                = wr;
        bus.req_addr[i*AddrW +: AddrW]  = a;
        bus.req_wdata[i*DataW +: DataW] = d;
        e.idx   = i;
        e.wr    = wr;
        e.addr  = a;
        e.wdata = d;
        e.rdata = slave_rdata(a);
        exp_q.push_back(e);
        req_cnt[i]++;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((exp_q.size() != 0) || busy || (bus.req_valid != '0)) && (n < budget));
        if (n >= budget) check_eq("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    // Requester driver: valid held until the monitor saw the handshake.
    initial begin
        bus.req_valid = '0;
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < NumReq; i++) begin
                if (acc_seen[i]) srv_cnt[i]++;
                bus.req_valid[i] = (req_cnt[i] != srv_cnt[i]);
            end
        end
    end

    // AXI4-Lite master model.
    initial begin
        bus.m_done  = 1'b0;
        bus.m_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            bus.m_done  = 1'b0;
            bus.m_rdata = '0;
            spur_flag   = 1'b0;
            if (!rst) begin
                slave_cnt = -1;
            end else if (spur_cnt != spur_done) begin
                spur_done++;
                spur_flag   = 1'b1;
                bus.m_done  = 1'b1;
                bus.m_rdata = 32'hFFFF_FFFF;
            end else if (bus.m_start) begin
                slave_cnt = slave_hang ? 100000 : slave_lat;
            end else if (slave_cnt > 0) begin
                slave_cnt--;
                if (slave_cnt == 0) begin
                    bus.m_done  = 1'b1;
                    bus.m_rdata = slave_rdata(bus.m_addr);
                    slave_cnt   = -1;
                end
            end
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            acc_seen      = '0;
            start_due     = 1'b0;
            start_off_due = 1'b0;
            rsp_due       = 1'b0;
            zero_due      = 1'b0;
            exp_q.delete();
        end else begin
            mon_acc  = bus.req_valid & bus.req_ready;
            acc_seen = mon_acc;
            if (bus.req_ready != '0) begin
                check_eq("ready_onehot", 64'($onehot(bus.req_ready)), 64'd1);
                check_eq("ready_subset", 64'(bus.req_ready & ~bus.req_valid), 64'd0);
            end
            if (start_off_due) begin
                start_off_due = 1'b0;
                check_eq("m_start_pulse", 64'(bus.m_start), 64'd0);
            end
            if (start_due) begin
                start_due     = 1'b0;
                start_off_due = 1'b1;
                check_eq("m_start", 64'(bus.m_start), 64'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q[0];
                    check_eq("grant_idx", 64'(grant_idx), 64'(mon_e.idx));
                    check_eq("start_addr", 64'(bus.m_addr), 64'(mon_e.addr));
                    check_eq("start_we", 64'(bus.m_write_en), 64'(mon_e.wr));
                end
            end else if (bus.m_start) begin
                check_eq("m_start_unexp", 64'(bus.m_start), 64'd0);
            end
            if (mon_acc != '0) begin
                if (exp_q.size() == 0) check_eq("grant_unexp", 64'(mon_acc), 64'd0);
                else check_eq("grant", 64'(mon_acc), 64'(onehot(exp_q[0].idx)));
                start_due = 1'b1;
            end
            if (zero_due) begin
                zero_due = 1'b0;
                check_eq("rsp_clear", 64'({bus.rsp_valid, bus.rsp_rdata}), 64'd0);
            end
            if (rsp_due) begin
                rsp_due  = 1'b0;
                zero_due = 1'b1;
                mon_e    = exp_q[0];
                check_eq("rsp_valid", 64'(bus.rsp_valid), 64'(onehot(mon_e.idx)));
                if (!mon_e.wr) check_eq("rsp_rdata", 64'(bus.rsp_rdata), 64'(mon_e.rdata));
                void'(exp_q.pop_front());
            end else if (bus.rsp_valid != '0) begin
                check_eq("rsp_unexp", 64'(bus.rsp_valid), 64'd0);
            end
            if (bus.m_done && !spur_flag) begin
                if (exp_q.size() == 0) begin
                    check_eq("done_unexp", 64'(bus.m_done), 64'd0);
                end else begin
                    mon_e = exp_q[0];
                    check_eq("hold_addr", 64'(bus.m_addr), 64'(mon_e.addr));
                    check_eq("hold_we", 64'(bus.m_write_en), 64'(mon_e.wr));
                    if (mon_e.wr) check_eq("hold_wdata", 64'(bus.m_wdata), 64'(mon_e.wdata));
                    rsp_due = 1'b1;
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_status"}, 64'({busy, grant_idx, proto_err}), 64'd0);
        check_eq({tag, "_req"}, 64'({bus.req_ready, bus.rsp_valid}), 64'd0);
        check_eq({tag, "_rdata"}, 64'(bus.rsp_rdata), 64'd0);
        check_eq({tag, "_mcmd"}, 64'({bus.m_start, bus.m_write_en}), 64'd0);
        check_eq({tag, "_maddr"}, {bus.m_addr, bus.m_wdata}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        #3;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // All four requesters at once from reset: strict order 0,1,2,3.
        @(posedge clk);
        #1;
        raise(0, 1'b1, 32'h0000_0100, 32'h1111_0000);
        raise(1, 1'b0, 32'h0000_0104, 32'h0);
        raise(2, 1'b1, 32'h0000_0108, 32'h3333_0000);
        raise(3, 1'b0, 32'h0000_010C, 32'h0);
        wait_idle(200);

        // Single write on requester 0.
        @(posedge clk);
        #1 raise(0, 1'b1, 32'h1000_0010, 32'hDEAD_BEEF);
        wait_idle(50);

        // Fairness: serve 1, then 0 and 1 together -> 0 first.
        slave_lat = 3;
        @(posedge clk);
        #1 raise(1, 1'b0, 32'h3000_0000, 32'h0);
        wait_idle(50);
        @(posedge clk);
        #1;
        raise(0, 1'b0, 32'h3000_0010, 32'h0);
        raise(1, 1'b1, 32'h3000_0014, 32'hCAFE_F00D);
        wait_idle(100);
        // Last owner 1: requesters 3 and 1 -> 3 first.
        @(posedge clk);
        #1;
        raise(3, 1'b1, 32'h3000_0020, 32'h0BAD_CAFE);
        raise(1, 1'b0, 32'h3000_0024, 32'h0);
        wait_idle(100);

        // Single read on requester 2.
        slave_lat = 2;
        @(posedge clk);
        #1 raise(2, 1'b0, 32'h2000_0004, 32'h0);
        wait_idle(50);

        // Spurious done while idle.
        @(posedge clk);
        #1 spur_cnt++;
        repeat (3) @(negedge clk);
        check_eq("proto_err_set", 64'(proto_err), 64'd1);
        check_eq("spur_idle", 64'(busy), 64'd0);
        @(posedge clk);
        #1 raise(3, 1'b0, 32'h5000_0008, 32'h0);
        wait_idle(50);
        check_eq("proto_err_sticky", 64'(proto_err), 64'd1);

        // Reset while waiting on a hung read.
        slave_hang = 1'b1;
        @(posedge clk);
        #1 raise(2, 1'b0, 32'h2000_0004, 32'h0);
        repeat (6) @(negedge clk);
        check_eq("hung_busy", 64'(busy), 64'd1);
        #2 rst = 1'b0;
        #1 check_all_zero("abort");
        repeat (2) @(negedge clk);
        slave_hang = 1'b0;
        #2 rst = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("post_reset_idle", 64'({busy, proto_err}), 64'd0);

        @(posedge clk);
        #1 raise(1, 1'b1, 32'h4000_0000, 32'h55AA_55AA);
        wait_idle(50);
        check_eq("post_reset_owner", 64'(grant_idx), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
